regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (reg_write, rd, rd_data) between two writeback requesters: A = ALU/execute, B = load/LSU.
- Each requester has a one-entry holding slot behind a valid/ready handshake. Round-robin arbitration picks one slot per cycle to drive the write port.
- Also gives decode pending-write hazard flags for two read indices, and a saturating count of committed writes.

---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A) and LSU (B) writeback slots.
// Optional forwarding outputs are enabled by defining WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [AW-1:0]    a_rd,
    input  logic [XLEN-1:0]  a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [AW-1:0]    b_rd,
    input  logic [XLEN-1:0]  b_data,
    output logic             wr_en,
    output logic [AW-1:0]    wr_rd,
    output logic [XLEN-1:0]  wr_data,
    input  logic [AW-1:0]    q_rs1,
    input  logic [AW-1:0]    q_rs2,
    output logic             rs1_pend,
    output logic             rs2_pend,
    output logic             last_grant,
    output logic [CNT_W-1:0] wr_count
`ifdef WB_BYPASS_EN
    ,
    output logic             rs1_fwd_valid,
    output logic             rs2_fwd_valid,
    output logic [XLEN-1:0]  rs1_fwd_data,
    output logic [XLEN-1:0]  rs2_fwd_data
`endif
);

    logic            slot_a_v;
    logic            slot_b_v;
    logic [AW-1:0]   slot_a_rd;
    logic [AW-1:0]   slot_b_rd;
    logic [XLEN-1:0] slot_a_data;
    logic [XLEN-1:0] slot_b_data;
    logic            ptr;
    logic            grant_a;
    logic            grant_b;
    logic            take_a;
    logic            take_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // x0 is never a real hazard, so a zero index never matches.
    function automatic logic slot_hit(input logic v, input logic [AW-1:0] rd,
                                      input logic [AW-1:0] q);
        return v && (rd == q) && (q != '0);
    endfunction

    // ptr = 1 gives B priority when both slots hold a write.
    always_comb begin
        grant_a = slot_a_v && (!slot_b_v || !ptr);
        grant_b = slot_b_v && (!slot_a_v || ptr);
    end

    assign a_ready = !slot_a_v || grant_a;
    assign b_ready = !slot_b_v || grant_b;
    assign take_a  = a_valid && a_ready;
    assign take_b  = b_valid && b_ready;

    always_comb begin
        wr_en   = grant_a || grant_b;
        wr_rd   = '0;
        wr_data = '0;
        if (grant_a) begin
            wr_rd   = slot_a_rd;
            wr_data = slot_a_data;
        end else if (grant_b) begin
            wr_rd   = slot_b_rd;
            wr_data = slot_b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_a_v   <= 1'b0;
            slot_b_v   <= 1'b0;
            ptr        <= 1'b0;
            last_grant <= 1'b0;
            wr_count   <= '0;
        end else begin
            if (take_a)       slot_a_v <= (a_rd != '0);
            else if (grant_a) slot_a_v <= 1'b0;
            if (take_b)       slot_b_v <= (b_rd != '0);
            else if (grant_b) slot_b_v <= 1'b0;
            if (grant_a || grant_b) begin
                ptr        <= grant_a;
                last_grant <= grant_b;
                wr_count   <= sat_inc(wr_count);
            end
        end
    end

    // Slot payload carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (take_a) begin
            slot_a_rd   <= a_rd;
            slot_a_data <= a_data;
        end
        if (take_b) begin
            slot_b_rd   <= b_rd;
            slot_b_data <= b_data;
        end
    end

    assign rs1_pend = slot_hit(slot_a_v, slot_a_rd, q_rs1) || slot_hit(slot_b_v, slot_b_rd, q_rs1);
    assign rs2_pend = slot_hit(slot_a_v, slot_a_rd, q_rs2) || slot_hit(slot_b_v, slot_b_rd, q_rs2);

`ifdef WB_BYPASS_EN
    logic m1a, m1b, m2a, m2b;

    // Two matching slots leave write order ambiguous, so forwarding is withheld.
    always_comb begin
        m1a           = slot_hit(slot_a_v, slot_a_rd, q_rs1);
        m1b           = slot_hit(slot_b_v, slot_b_rd, q_rs1);
        m2a           = slot_hit(slot_a_v, slot_a_rd, q_rs2);
        m2b           = slot_hit(slot_b_v, slot_b_rd, q_rs2);
        rs1_fwd_valid = m1a ^ m1b;
        rs2_fwd_valid = m2a ^ m2b;
        rs1_fwd_data  = '0;
        rs2_fwd_data  = '0;
        if (m1a && !m1b)      rs1_fwd_data = slot_a_data;
        else if (m1b && !m1a) rs1_fwd_data = slot_b_data;
        if (m2a && !m2b)      rs2_fwd_data = slot_a_data;
        else if (m2b && !m2a) rs2_fwd_data = slot_b_data;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writebacks are queued as requests are
// accepted and popped when the write port fires; a CNT_W=4 twin checks counter saturation.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, b_valid;
    logic [AW-1:0]   a_rd, b_rd, q_rs1, q_rs2;
    logic [XLEN-1:0] a_data, b_data;
    logic            a_ready, b_ready, wr_en, rs1_pend, rs2_pend, last_grant;
    logic [AW-1:0]   wr_rd;
    logic [XLEN-1:0] wr_data;
    logic [15:0]     wr_count;
    logic            a_ready4, b_ready4, wr_en4, rs1_pend4, rs2_pend4, last_grant4;
    logic [AW-1:0]   wr_rd4;
    logic [XLEN-1:0] wr_data4;
    logic [3:0]      wr_count4;
`ifdef WB_BYPASS_EN
    logic            rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_valid4, rs2_fwd_valid4;
    logic [XLEN-1:0] rs1_fwd_data, rs2_fwd_data, rs1_fwd_data4, rs2_fwd_data4;
`endif

    int  n_chk  = 0;
    int  n_fail = 0;
    wb_t exp_q[$];
    wb_t got;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
        .last_grant(last_grant), .wr_count(wr_count)
`ifdef WB_BYPASS_EN
        , .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
        .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data)
`endif
    );

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready4), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready4), .b_rd(b_rd), .b_data(b_data),
        .wr_en(wr_en4), .wr_rd(wr_rd4), .wr_data(wr_data4),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_pend(rs1_pend4), .rs2_pend(rs2_pend4),
        .last_grant(last_grant4), .wr_count(wr_count4)
`ifdef WB_BYPASS_EN
        , .rs1_fwd_valid(rs1_fwd_valid4), .rs2_fwd_valid(rs2_fwd_valid4),
        .rs1_fwd_data(rs1_fwd_data4), .rs2_fwd_data(rs2_fwd_data4)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic wb_t mk(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
        wb_t w;
        w.rd   = rd;
        w.data = data;
        return w;
    endfunction

    // Every write-port cycle must match the oldest expected writeback.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("twin_wr_en", 32'(wr_en4), 32'(wr_en));
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check_eq("wb_unexpected", 32'(wr_en), 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    check_eq("wb_rd", 32'(wr_rd), 32'(got.rd));
                    check_eq("wb_data", wr_data, got.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ia, ib, total;
        logic ar, br;
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
        q_rs1 = '0; q_rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_wr_rd", 32'(wr_rd), 32'd0);
        check_eq("rst_wr_data", wr_data, 32'd0);
        check_eq("rst_a_ready", 32'(a_ready), 32'd1);
        check_eq("rst_b_ready", 32'(b_ready), 32'd1);
        check_eq("rst_last_grant", 32'(last_grant), 32'd0);
        check_eq("rst_wr_count", 32'(wr_count), 32'd0);
        check_eq("rst_pend", 32'({rs1_pend, rs2_pend}), 32'd0);
        rst = 1'b0;
        tick();

        // Single A write
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF; q_rs1 = 5'd5;
        check_eq("a_ready_empty", 32'(a_ready), 32'd1);
        check_eq("pend_ignores_input", 32'(rs1_pend), 32'd0);
        exp_q.push_back(mk(5'd5, 32'hDEADBEEF));
        tick();
        a_valid = 1'b0;
        check_eq("single_wr_en", 32'(wr_en), 32'd1);
        check_eq("single_wr_rd", 32'(wr_rd), 32'd5);
        check_eq("single_pend", 32'(rs1_pend), 32'd1);
        tick();
        check_eq("single_idle", 32'(wr_en), 32'd0);
        check_eq("single_count", 32'(wr_count), 32'd1);
        check_eq("single_last", 32'(last_grant), 32'd0);
        check_eq("single_pend_clr", 32'(rs1_pend), 32'd0);

        // Pointer now favours B, so a simultaneous pair drains B first
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h22;
        exp_q.push_back(mk(5'd4, 32'h22));
        exp_q.push_back(mk(5'd3, 32'h11));
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check_eq("rr_b_first", 32'(wr_rd), 32'd4);
        check_eq("rr_a_blocked", 32'(a_ready), 32'd0);
        check_eq("rr_b_draining", 32'(b_ready), 32'd1);
        tick();
        check_eq("rr_last_b", 32'(last_grant), 32'd1);
        check_eq("rr_a_second", 32'(wr_rd), 32'd3);
        tick();
        check_eq("rr_last_a", 32'(last_grant), 32'd0);
        check_eq("rr_count", 32'(wr_count), 32'd3);

        // Reset mid-cycle with both slots full discards the held writes
        a_valid = 1'b1; a_rd = 5'd9;  a_data = 32'h99;
        b_valid = 1'b1; b_rd = 5'd10; b_data = 32'hAA;
        q_rs1 = 5'd9; q_rs2 = 5'd10;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check_eq("full_pend", 32'({rs1_pend, rs2_pend}), 32'd3);
        check_eq("full_a_blocked", 32'(a_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("mid_rst_wr_data", wr_data, 32'd0);
        check_eq("mid_rst_pend", 32'({rs1_pend, rs2_pend}), 32'd0);
        check_eq("mid_rst_count", 32'(wr_count), 32'd0);
        check_eq("mid_rst_last", 32'(last_grant), 32'd0);
        check_eq("mid_rst_a_ready", 32'(a_ready), 32'd1);
        rst = 1'b0;
        tick();
        check_eq("post_rst_idle", 32'(wr_en), 32'd0);
        check_eq("post_rst_ready", 32'({a_ready, b_ready}), 32'd3);

        // Contention from reset: A first, then B
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h22;
        exp_q.push_back(mk(5'd3, 32'h11));
        exp_q.push_back(mk(5'd4, 32'h22));
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check_eq("cont_a_first", 32'(wr_rd), 32'd3);
        tick();
        check_eq("cont_last_a", 32'(last_grant), 32'd0);
        check_eq("cont_b_second", 32'(wr_rd), 32'd4);
        tick();
        check_eq("cont_last_b", 32'(last_grant), 32'd1);
        check_eq("cont_count", 32'(wr_count), 32'd2);

        // Writes to x0 are accepted and dropped
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hBAD0BAD0; q_rs1 = 5'd0;
        check_eq("x0_b_ready", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
        check_eq("x0_no_write", 32'(wr_en), 32'd0);
        check_eq("x0_wr_rd", 32'(wr_rd), 32'd0);
        check_eq("x0_wr_data", wr_data, 32'd0);
        check_eq("x0_pend", 32'(rs1_pend), 32'd0);
        check_eq("x0_b_ready_after", 32'(b_ready), 32'd1);
        tick();
        check_eq("x0_count", 32'(wr_count), 32'd2);

        // Streaming from reset: both producers always valid
        rst = 1'b1;
        #1 rst = 1'b0;
        tick();
        ia = 0; ib = 0;
        for (int k = 0; k < 20; k++) begin
            a_valid = 1'b1; a_rd = 5'(16 + ia % 8); a_data = 32'hA0000000 | 32'(ia);
            b_valid = 1'b1; b_rd = 5'(24 + ib % 8); b_data = 32'hB0000000 | 32'(ib);
            @(negedge clk);
            if (k > 0) begin
                check_eq("strm_wr_en", 32'(wr_en), 32'd1);
                check_eq("strm_one_ready", 32'(a_ready) + 32'(b_ready), 32'd1);
            end
            ar = a_ready;
            br = b_ready;
            @(posedge clk);
            #1;
            if (ar) begin
                exp_q.push_back(mk(5'(16 + ia % 8), 32'hA0000000 | 32'(ia)));
                ia++;
            end
            if (br) begin
                exp_q.push_back(mk(5'(24 + ib % 8), 32'hB0000000 | 32'(ib)));
                ib++;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        total = ia + ib;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!wr_en) break;
        end
        check_eq("strm_drained", 32'(exp_q.size()), 32'd0);
        check_eq("strm_count", 32'(wr_count), 32'(total));
        check_eq("strm_count_sat", 32'(wr_count4), (total > 15) ? 32'd15 : 32'(total));
        @(posedge clk);
        #1;

`ifdef WB_BYPASS_EN
        // Forwarding: ambiguous with two matches, valid with one
        rst = 1'b1;
        #1 rst = 1'b0;
        tick();
        q_rs1 = 5'd0; q_rs2 = 5'd7;
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h1234;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h5678;
        exp_q.push_back(mk(5'd7, 32'h1234));
        exp_q.push_back(mk(5'd7, 32'h5678));
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check_eq("fwd_both_valid", 32'(rs2_fwd_valid), 32'd0);
        check_eq("fwd_both_pend", 32'(rs2_pend), 32'd1);
        check_eq("fwd_x0_valid", 32'(rs1_fwd_valid), 32'd0);
        check_eq("fwd_x0_data", rs1_fwd_data, 32'd0);
        tick();
        check_eq("fwd_b_only_valid", 32'(rs2_fwd_valid), 32'd1);
        check_eq("fwd_b_only_data", rs2_fwd_data, 32'h5678);
        tick();
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h1234;
        exp_q.push_back(mk(5'd7, 32'h1234));
        tick();
        a_valid = 1'b0;
        check_eq("fwd_a_valid", 32'(rs2_fwd_valid), 32'd1);
        check_eq("fwd_a_data", rs2_fwd_data, 32'h1234);
        check_eq("fwd_a_pend", 32'(rs2_pend), 32'd1);
        tick();
        tick();
`endif

        check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
